// File: rtl/w_backward_pkg.sv
// -----------------------------------------------------------------------------
// w_backward_pkg
// Shared definitions for the AXI4 write-response (B) packing path:
//   - field widths and bit positions of the 14-bit packed B word
//   - skid-buffer occupancy states
//   - AXI write-response encodings
//   - helpers to pack a beat and to classify a response as an error
// -----------------------------------------------------------------------------
package w_backward_pkg;

    localparam int B_ID_W   = 8;
    localparam int B_RESP_W = 2;
    localparam int B_USER_W = 4;
    localparam int B_PACK_W = 14;

    // Bit positions inside the packed word {BID, BRESP, BUSER}
    localparam int B_USER_LSB = 0;
    localparam int B_USER_MSB = 3;
    localparam int B_RESP_LSB = 4;
    localparam int B_RESP_MSB = 5;
    localparam int B_ID_LSB   = 6;
    localparam int B_ID_MSB   = 13;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // AXI write-response encodings
    localparam logic [B_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [B_RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [B_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [B_RESP_W-1:0] RESP_DECERR = 2'b11;

    // Pack the B fields into one bus-internal word
    function automatic logic [B_PACK_W-1:0] pack_b(
        input logic [B_ID_W-1:0]   id,
        input logic [B_RESP_W-1:0] resp,
        input logic [B_USER_W-1:0] user
    );
        return {id, resp, user};
    endfunction

    // SLVERR and DECERR both have the upper response bit set
    function automatic logic resp_is_error(input logic [B_RESP_W-1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/b_skid_buffer.sv
// -----------------------------------------------------------------------------
// b_skid_buffer
// Generic 2-entry skid buffer. All outputs are registered, so there is no
// combinational path from in_valid/out_ready to in_ready/out_valid, yet one
// beat per cycle is sustained while the consumer keeps out_ready high.
//
// Parameters:
//   W          payload width
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset; discards stored beats
//   in_data    input payload
//   in_valid   input valid
//   in_ready   registered input ready (0 out of reset, 0 when both entries full)
//   out_data   registered output payload (held while out_valid && !out_ready)
//   out_valid  registered output valid
//   out_ready  consumer accept
// -----------------------------------------------------------------------------
module b_skid_buffer
    import w_backward_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_e  state_r;
    skid_state_e  state_nxt_s;
    logic [W-1:0] out_data_r;
    logic [W-1:0] skid_data_r;
    logic         out_valid_r;
    logic         in_ready_r;

    logic         accept_s;
    logic         fire_s;
    logic         load_out_in_s;
    logic         load_out_skid_s;
    logic         load_skid_s;

    assign accept_s = in_valid && in_ready_r;
    assign fire_s   = out_valid_r && out_ready;

    // Next-state and datapath load selection
    always_comb begin
        state_nxt_s     = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_out_in_s = 1'b1;
                    state_nxt_s   = ST_ONE;
                end else begin
                    state_nxt_s   = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && fire_s) begin
                    // OUT drains and refills in the same edge
                    load_out_in_s = 1'b1;
                    state_nxt_s   = ST_ONE;
                end else if (accept_s) begin
                    // OUT is stalled, park the new beat in SKID
                    load_skid_s   = 1'b1;
                    state_nxt_s   = ST_FULL;
                end else if (fire_s) begin
                    state_nxt_s   = ST_EMPTY;
                end else begin
                    state_nxt_s   = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen
                if (fire_s) begin
                    load_out_skid_s = 1'b1;
                    state_nxt_s     = ST_ONE;
                end else begin
                    state_nxt_s     = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, flags and storage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            out_data_r  <= {W{1'b0}};
            skid_data_r <= {W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            in_ready_r  <= (state_nxt_s != ST_FULL);
            if (load_out_in_s) begin
                out_data_r <= in_data;
            end else if (load_out_skid_s) begin
                out_data_r <= skid_data_r;
            end else begin
                out_data_r <= out_data_r;
            end
            if (load_skid_s) begin
                skid_data_r <= in_data;
            end else begin
                skid_data_r <= skid_data_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: rtl/w_backward_combiner.sv
// -----------------------------------------------------------------------------
// w_backward_combiner
// Packs the AXI4 B channel of a slave port into the 14-bit bus-internal word
// DATA = {BID, BRESP, BUSER} with VALID/READY handshake, through a registered
// 2-entry skid buffer.
//
// Optional feature macro: WBC_ERR_COUNT_EN
//   defined   -> ERR_CNT port and a saturating count of accepted error
//                responses (BRESP = SLVERR or DECERR)
//   undefined -> no counter, no ERR_CNT port, identical datapath
//
// Ports:
//   CLK      clock, rising edge
//   RESET    synchronous active-high reset
//   BID      write-response ID from slave
//   BRESP    write response
//   BUSER    user sideband
//   BVALID   slave response valid
//   BREADY   registered ready to slave
//   DATA     registered packed word
//   VALID    registered output valid
//   READY    downstream accept
//   ERR_CNT  error counter (only with WBC_ERR_COUNT_EN), width ERR_CNT_W 1..32
// -----------------------------------------------------------------------------
module w_backward_combiner
    import w_backward_pkg::*;
`ifdef WBC_ERR_COUNT_EN
#(
    parameter int ERR_CNT_W = 16
)
`endif
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [B_ID_W-1:0]   BID,
    input  logic [B_RESP_W-1:0] BRESP,
    input  logic [B_USER_W-1:0] BUSER,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [B_PACK_W-1:0] DATA,
    output logic                VALID,
`ifdef WBC_ERR_COUNT_EN
    input  logic                READY,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`else
    input  logic                READY
`endif
);

    logic [B_PACK_W-1:0] packed_s;

    assign packed_s = pack_b(BID, BRESP, BUSER);

    b_skid_buffer #(
        .W (B_PACK_W)
    ) u_skid (
        .clk       (CLK),
        .reset     (RESET),
        .in_data   (packed_s),
        .in_valid  (BVALID),
        .in_ready  (BREADY),
        .out_data  (DATA),
        .out_valid (VALID),
        .out_ready (READY)
    );

`ifdef WBC_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Saturating count of accepted SLVERR/DECERR responses
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (BVALID && BREADY && resp_is_error(BRESP)
                     && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign ERR_CNT = err_cnt_r;
`endif

endmodule

// File: tb/tb_w_backward_combiner.sv
// -----------------------------------------------------------------------------
// tb_w_backward_combiner
// Self-checking bench: a queue-based reference model of the B-word packer is
// compared against the DUT on every cycle, with directed and random stimulus
// and a few hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_w_backward_combiner;

    localparam int CNT_W   = 2;
    localparam int ERR_MAX = 3;

    logic        CLK;
    logic        RESET;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic [3:0]  BUSER;
    logic        BVALID;
    logic        BREADY;
    logic [13:0] DATA;
    logic        VALID;
    logic        READY;
`ifdef WBC_ERR_COUNT_EN
    logic [CNT_W-1:0] ERR_CNT;
`endif

    int checks = 0;
    int errors = 0;

`ifdef WBC_ERR_COUNT_EN
    w_backward_combiner #(.ERR_CNT_W(CNT_W)) dut (
`else
    w_backward_combiner dut (
`endif
        .CLK    (CLK),
        .RESET  (RESET),
        .BID    (BID),
        .BRESP  (BRESP),
        .BUSER  (BUSER),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .DATA   (DATA),
        .VALID  (VALID),
`ifdef WBC_ERR_COUNT_EN
        .READY  (READY),
        .ERR_CNT(ERR_CNT)
`else
        .READY  (READY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Everything accepted and not yet delivered, oldest first.
    logic [13:0] q[$];
    bit          bready_m = 1'b0;
    bit          valid_m  = 1'b0;
    logic [13:0] data_m   = 14'h0;
    int          err_m    = 0;
    bit          live     = 1'b0;

    task automatic model_step();
        bit acc;
        bit fire;
        if (RESET) begin
            q.delete();
            bready_m = 1'b0;
            err_m    = 0;
            live     = 1'b1;
        end else if (live) begin
            acc  = BVALID && bready_m;
            fire = (q.size() > 0) && READY;
            if (acc && BRESP[1] && err_m < ERR_MAX) err_m++;
            if (fire) void'(q.pop_front());
            if (acc) q.push_back({BID, BRESP, BUSER});
            bready_m = (q.size() < 2);
        end
        valid_m = (q.size() > 0);
        if (valid_m) data_m = q[0];
    endtask

    always @(posedge CLK) model_step();

    // ---------------- compare process ----------------
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [13:0] prev_data  = 14'h0;

    always @(negedge CLK) begin
        if (live) begin
            chk("bready", 32'(BREADY), 32'(bready_m));
            chk("valid", 32'(VALID), 32'(valid_m));
            if (valid_m) chk("data", 32'(DATA), 32'(data_m));
            if (prev_valid && !prev_ready && !prev_rst && VALID)
                chk("hold", 32'(DATA), 32'(prev_data));
`ifdef WBC_ERR_COUNT_EN
            chk("err_cnt", 32'(ERR_CNT), 32'(err_m));
`endif
        end
        prev_valid <= VALID;
        prev_ready <= READY;
        prev_rst   <= RESET;
        prev_data  <= DATA;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] id, input logic [1:0] r, input logic [3:0] u);
        BVALID = v;
        BID    = id;
        BRESP  = r;
        BUSER  = u;
    endtask

    initial begin
        RESET = 1'b1;
        READY = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        repeat (3) step();

        // ---- single beat after reset ----
        RESET = 1'b0;
        chk("rst_bready", 32'(BREADY), 32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_data", 32'(DATA), 32'h0);
        drive(1'b1, 8'h5A, 2'b00, 4'h3);
        READY = 1'b1;
        step();
        chk("first_bready", 32'(BREADY), 32'd1);
        chk("first_valid_pre", 32'(VALID), 32'd0);
        step();
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        chk("first_valid", 32'(VALID), 32'd1);
        chk("first_data", 32'(DATA), 32'h1683);
        step();
        chk("first_valid_drop", 32'(VALID), 32'd0);

        // ---- 16 back-to-back beats ----
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 2'b00, 4'(i));
            step();
            chk("b2b_valid", 32'(VALID), 32'd1);
            chk("b2b_id", 32'(DATA[13:6]), 32'(i));
        end
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        step();
        chk("b2b_end", 32'(VALID), 32'd0);

        // ---- stall with 3 beats offered ----
        READY = 1'b0;
        drive(1'b1, 8'h20, 2'b01, 4'h1);
        step();
        drive(1'b1, 8'h21, 2'b01, 4'h2);
        step();
        chk("stall_bready", 32'(BREADY), 32'd0);
        chk("stall_hold0", 32'(DATA[13:6]), 32'h20);
        drive(1'b1, 8'h22, 2'b01, 4'h3);
        step();
        chk("stall_bready2", 32'(BREADY), 32'd0);
        chk("stall_hold1", 32'(DATA[13:6]), 32'h20);
        READY = 1'b1;
        step();
        chk("drain_b1", 32'(DATA[13:6]), 32'h21);
        step();
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        chk("drain_b2", 32'(DATA[13:6]), 32'h22);
        step();
        chk("drain_end", 32'(VALID), 32'd0);

        // ---- reset while FULL ----
        READY = 1'b0;
        drive(1'b1, 8'h30, 2'b10, 4'h5);
        step();
        drive(1'b1, 8'h31, 2'b11, 4'h6);
        step();
        chk("full_bready", 32'(BREADY), 32'd0);
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("frst_valid", 32'(VALID), 32'd0);
        chk("frst_data", 32'(DATA), 32'h0);
        chk("frst_bready", 32'(BREADY), 32'd0);
        READY = 1'b1;
        repeat (4) begin
            step();
            chk("frst_nobeat", 32'(VALID), 32'd0);
        end

        // ---- random traffic ----
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 4'($urandom));
            if (c < 5000) READY = 1'($urandom_range(0, 1));
            else          READY = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        READY = 1'b1;
        repeat (3) step();
        chk("rand_drained", 32'(VALID), 32'd0);

`ifdef WBC_ERR_COUNT_EN
        // ---- error counter ----
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        drive(1'b1, 8'h01, 2'b00, 4'h0); step();
        drive(1'b1, 8'h02, 2'b10, 4'h0); step();
        drive(1'b1, 8'h03, 2'b11, 4'h0); step();
        drive(1'b1, 8'h04, 2'b01, 4'h0); step();
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        step();
        chk("err_two", 32'(ERR_CNT), 32'd2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'(k), 2'b10, 4'h0);
            step();
        end
        drive(1'b0, 8'h00, 2'b00, 4'h0);
        step();
        chk("err_sat", 32'(ERR_CNT), 32'd3);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_backward_combiner.md
# w_backward_combiner

Packs the AXI4 write-response (B) channel from a slave port into the 14-bit bus-internal word `DATA`/`VALID`/`READY`, ready for transport across the interconnect. It sits at the slave-facing end of the B path and is the packing counterpart of the B-channel separater on the master side. A 2-entry skid buffer registers `DATA`/`VALID` and `BREADY`, breaking every combinational path while sustaining one beat per cycle.

## Interface
- `ERR_CNT_W`, 16, width of the optional error counter; legal range 1..32.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `BID`  in  8  write-response ID from the slave.
- `BRESP`  in  2  write response.
- `BUSER`  in  4  user sideband.
- `BVALID`  in  1  slave response valid.
- `BREADY`  out  1  registered; reset 0.
- `DATA`  out  14  packed word `{BID,BRESP,BUSER}`: BID at [13:6], BRESP at [5:4], BUSER at [3:0]; registered; reset 0.
- `VALID`  out  1  registered; reset 0.
- `READY`  in  1  downstream accept.
- `ERR_CNT`  out  `ERR_CNT_W`  present only with `WBC_ERR_COUNT_EN`; reset 0.

## Operation
- Input beat accepted when `BVALID && BREADY`; output beat when `VALID && READY`.
- Storage: output register (OUT) drives `DATA`/`VALID`; skid register (SKID) holds one overflow beat.
- States: EMPTY (OUT and SKID empty), ONE (OUT full), FULL (OUT and SKID full).
- EMPTY: accept -> OUT loads input, go to ONE.
- ONE: accept only -> FULL, SKID loads input. Output only -> EMPTY. Both -> OUT reloads input, stay ONE. Neither -> hold.
- FULL: output -> OUT loads SKID, go to ONE. No accept is possible because `BREADY` is 0.
- `BREADY` next = 1 unless the next state is FULL. An input arriving while `BREADY` = 0 is ignored.
- `DATA` is held stable while `VALID && !READY`. `VALID` never drops without a handshake.
- Beats leave in arrival order. No field is altered.
- While `RESET` is high, the state returns to EMPTY, stored beats are discarded, and `BREADY`, `VALID` and `DATA` become 0 on that edge. Reset mid-transfer drops both buffered beats.

## Timing
- Latency: input accepted at edge N -> `VALID`/`DATA` visible after edge N (one cycle) when OUT is empty or drained at the same edge.
- Throughput: one beat per cycle with `READY` held at 1.
- After `RESET` deasserts: `BREADY` = 0 for the first cycle and rises at the following edge.
- Worst case: two beats stored. `BREADY` falls the edge after the second accept and rises the edge after OUT drains to SKID.
- No combinational path between any two of `BVALID`, `BREADY`, `READY`, `VALID`.

## Configuration
- `WBC_ERR_COUNT_EN` defined: `ERR_CNT` port exists. It increments on every accepted input beat with `BRESP[1]` = 1 (SLVERR 2'b10 or DECERR 2'b11). It saturates at all-ones, resets to 0, and updates the edge after acceptance.
- `WBC_ERR_COUNT_EN` undefined: no port, no counter logic. Datapath behaviour is identical.

## Structure
- Shared package `w_backward_pkg` holds:
  - field widths `B_ID_W`=8, `B_RESP_W`=2, `B_USER_W`=4, `B_PACK_W`=14;
  - field bit-position constants;
  - the 3-state enum;
  - response encodings OKAY/EXOKAY/SLVERR/DECERR.
- One sub-module: `b_skid_buffer`, a generic width-parameterised 2-entry skid buffer. This block instantiates it with width `B_PACK_W` and adds packing plus the optional counter.

## Test plan
- Reset, then single beat BID=0x5A, BRESP=2'b00, BUSER=0x3, with `READY`=1 -> `DATA`=14'h1683 and `VALID` high for exactly one cycle; `BREADY` 0 in the first post-reset cycle.
- 16 back-to-back beats with IDs 0..15 and `READY`=1 -> 16 consecutive output cycles, in order, no bubbles.
- `READY`=0 while 3 beats are offered -> first two accepted, `BREADY` falls after the second, `DATA` holds beat 0. Raise `READY` -> beats 0, 1, 2 emerge in order.
- Random `BVALID`/`READY` over 10k cycles against a scoreboard -> zero loss, duplication or reorder; `DATA` stable whenever `VALID && !READY`.
- Assert `RESET` for one cycle while in FULL -> `VALID`=0, `DATA`=0, `BREADY`=0 at the next edge; neither stored beat ever appears.
- With `WBC_ERR_COUNT_EN`, send BRESP sequence 00, 10, 11, 01 -> `ERR_CNT`=2. Preload the counter near saturation with `ERR_CNT_W`=2 and send 5 errors -> `ERR_CNT` stays at 3.
